blk_arbiter: RTL and testbench
==============================

// Module: blk_arbiter
// PURPOSE
//  Round-robin block arbiter between NCH channel processors and the common output stream.
//  Polls each enabled channel with give/have and copies one complete block per grant to the output.
//  A block is the control word (CW) plus the L data words that follow it.
//  Sits on clk next to the channel FIFOs and feeds the link/VME readout path. Blocks are never interleaved.
// PARAMETERS
//  NCH   16   number of channel processors served
//  TOUT  255  max idle clk cycles inside a block before abort (8-bit counter)
// PORTS
//  clk       in   1       125 MHz system clock (the only clock)
//  reset     in   1       synchronous, active-high reset
//  chen      in   NCH     per-channel enable mask; disabled channels are skipped
//  give      out  NCH     request to channel i (combinational, one-hot or zero)
//  have      in   NCH     channel ack, combinational with give; data word valid in same cycle
//  chdata    in   16*NCH  channel i dout at [16*i+15:16*i]
//  odata     out  16      output word (registered)
//  ovalid    out  1       odata valid
//  osop      out  1       first word (CW) of block
//  oeop      out  1       last word of block
//  oready    in   1       downstream can take a word this cycle
//  err       out  1       1-clk pulse: bad CW or timeout abort
//  blkcnt    out  32      count of completed blocks, wraps
// BEHAVIOUR
//  Reset: give=0, odata=0, ovalid=osop=oeop=0, err=0, blkcnt=0, ptr=0, state=SCAN.
//  Word transfer: word taken iff give[ptr] & have[ptr]. It is registered to odata/ovalid one clk later.
//  give[ptr] = (state!=ABORT) & chen[ptr] & oready. A low oready stalls the transfer with no loss.
//  CW format: bit15=1, [14:9]=channel num, [8:0]=L (data words after CW).
//  SCAN:
//   - If chen[ptr]=0 or have[ptr]=0: ptr<=ptr+1 (wraps at NCH-1 -> 0). Each channel costs 1 clk.
//   - On transfer with bit15=1: emit word with osop=1. Set rem<=L. If L==0, also oeop=1, blkcnt++, ptr+1, stay in SCAN.
//     Otherwise go to DATA.
//   - On transfer with bit15=0 (desync): drop the word and pulse err. ptr stays, so a desynced channel is drained word by word.
//  DATA:
//   - Each transfer emits the word and decrements rem. On rem==1: oeop=1, blkcnt++, ptr+1, go to SCAN.
//   - tcnt counts clk with oready=1 and no have. It clears on every transfer.
//   - If tcnt reaches TOUT: go to ABORT.
//  ABORT (1 clk): emit nothing, pulse err, ptr+1, go to SCAN. Downstream sees a block with osop but no oeop.
//  Data words are copied unmodified. The CW channel field is not checked against ptr.
//  A chen bit dropped mid-block takes effect only after that block ends (give for ptr is held via a latched enable).
//  Reset mid-block: the partial block is lost and the output returns to its reset values next clk.
//   Resyncing the channel is the channel's responsibility.
//  Output latency: odata is 1 clk after the have cycle.
//  Throughput: 1 word/clk while oready=1. Gap between blocks >= 1 clk per skipped channel.
// TESTING
//  1. ch0 holds block CW=0x8004 (L=4) plus 4 words, oready=1 -> 5 consecutive ovalid; osop on 0x8004,
//     oeop on 4th data word; blkcnt=1.
//  2. ch2 and ch5 each hold one L=2 block, chen=all -> ch2 block fully precedes ch5 block, no interleave;
//     ptr then continues to 6.
//  3. oready toggled 1/0 every clk during an L=10 block -> give low on oready=0 clks; 11 words out, in order, none duplicated.
//  4. Channel has stops after 3 of 8 data words, TOUT=255 -> err pulse 256 clk after last word, no oeop, ptr advances, blkcnt unchanged.
//  5. First word 0x1234 (bit15=0) then valid CW 0x8001+1 word on ch1 -> err 1 pulse, 0x1234 dropped; following block passes intact.
//  6. chen=0x0001, blocks pending on ch0 and ch3 -> only ch0 served; assert reset mid-block -> all outputs 0 next clk, blkcnt=0.

Source files
------------

// File: rtl/blk_arbiter_if.sv
// Channel-side and output-stream signals of the round-robin block arbiter.
// The arbiter connects through the slave modport; the channel/downstream side uses master.
interface blk_arbiter_if #(
  parameter int unsigned NCH = 16
);
  logic [NCH-1:0]    chen;
  logic [NCH-1:0]    give;
  logic [NCH-1:0]    have;
  logic [16*NCH-1:0] chdata;
  logic [15:0]       odata;
  logic              ovalid;
  logic              osop;
  logic              oeop;
  logic              oready;
  logic              err;
  logic [31:0]       blkcnt;

  modport slave (
    input  chen, have, chdata, oready,
    output give, odata, ovalid, osop, oeop, err, blkcnt
  );

  modport master (
    output chen, have, chdata, oready,
    input  give, odata, ovalid, osop, oeop, err, blkcnt
  );
endinterface

// File: rtl/blk_arbiter.sv
// Round-robin arbiter copying one complete CW-led block per grant from NCH channels
// to a single registered output stream; blocks are never interleaved.
module blk_arbiter #(
  parameter int unsigned NCH  = 16,
  parameter int unsigned TOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  blk_arbiter_if.slave bus
);
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {SCAN, DATA, ABORT} state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [8:0]    rem_q;
  logic [7:0]    tcnt_q;
  logic          en_q;
  logic [15:0]   odata_q;
  logic          ovalid_q;
  logic          osop_q;
  logic          oeop_q;
  logic          err_q;
  logic [31:0]   blkcnt_q;

  logic [NCH-1:0] give;
  logic [PW-1:0]  ptr_inc;
  logic [15:0]    word;
  logic           en_cur;
  logic           xfer;

  // Inside a block the enable latched with the CW holds the grant, so a chen
  // drop only takes effect once the block has finished.
  always_comb begin
    give    = '0;
    en_cur  = (state_q == DATA) ? en_q : bus.chen[ptr_q];
    word    = bus.chdata[16*ptr_q +: 16];
    ptr_inc = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
    if (!reset && (state_q != ABORT) && en_cur && bus.oready)
      give[ptr_q] = 1'b1;
    xfer    = give[ptr_q] & bus.have[ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SCAN;
      ptr_q    <= '0;
      rem_q    <= '0;
      tcnt_q   <= '0;
      en_q     <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      err_q    <= 1'b0;
      blkcnt_q <= '0;
    end else begin
      ovalid_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        SCAN: begin
          if (!xfer) begin
            ptr_q <= ptr_inc;
          end else if (word[15]) begin
            odata_q  <= word;
            ovalid_q <= 1'b1;
            osop_q   <= 1'b1;
            rem_q    <= word[8:0];
            tcnt_q   <= '0;
            en_q     <= bus.chen[ptr_q];
            if (word[8:0] == 9'd0) begin
              oeop_q   <= 1'b1;
              blkcnt_q <= blkcnt_q + 32'd1;
              ptr_q    <= ptr_inc;
            end else begin
              state_q <= DATA;
            end
          end else begin
            // Desynced word: drop it and stay on this channel to drain it.
            err_q <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            odata_q  <= word;
            ovalid_q <= 1'b1;
            rem_q    <= rem_q - 9'd1;
            tcnt_q   <= '0;
            if (rem_q == 9'd1) begin
              oeop_q   <= 1'b1;
              blkcnt_q <= blkcnt_q + 32'd1;
              ptr_q    <= ptr_inc;
              state_q  <= SCAN;
            end
          end else if (bus.oready) begin
            tcnt_q <= tcnt_q + 8'd1;
            if (tcnt_q == 8'(TOUT - 1))
              state_q <= ABORT;
          end
        end
        ABORT: begin
          err_q   <= 1'b1;
          ptr_q   <= ptr_inc;
          state_q <= SCAN;
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign bus.give   = give;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.osop   = osop_q;
  assign bus.oeop   = oeop_q;
  assign bus.err    = err_q;
  assign bus.blkcnt = blkcnt_q;
endmodule

// File: tb/tb_blk_arbiter.sv
// Directed bench for blk_arbiter: per-channel word FIFO models plus an output scoreboard.
module tb_blk_arbiter;
  localparam int unsigned NCH  = 16;
  localparam int unsigned TOUT = 255;

  logic clk;
  logic reset;
  logic flush;

  blk_arbiter_if #(.NCH(NCH)) bus ();

  blk_arbiter #(.NCH(NCH), .TOUT(TOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [NCH][256];
  int          head [NCH];
  int          tail [NCH];

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int err_n = 0;
  int err_cyc = 0;
  int last_v_cyc = 0;
  int sop_cyc = 0;
  int n_pop = 0;

  always_comb begin
    bus.have   = '0;
    bus.chdata = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.chdata[16*i +: 16] = mem[i][head[i][7:0]];
      bus.have[i]            = bus.give[i] && (head[i] != tail[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (flush) head[i] <= tail[i];
      else if (bus.give[i] && bus.have[i]) head[i] <= head[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chpush(input int ch, input logic [15:0] w);
    mem[ch][tail[ch]] = w;
    tail[ch]++;
  endtask

  task automatic expect_w(input logic [15:0] w, input logic sop, input logic eop);
    exp_t e;
    e.d = w; e.sop = sop; e.eop = eop;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.ovalid) begin
      last_v_cyc = cyc;
      if (bus.osop) sop_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {14'd0, bus.odata, bus.osop, bus.oeop}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("out_word", {14'd0, bus.odata, bus.osop, bus.oeop}, {14'd0, e});
      end
    end
    if (bus.err) begin
      err_n++;
      err_cyc = cyc;
    end
  endtask

  task automatic drain(input int budget, input string tag);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    int p0;
    int h3;
    flush      = 1'b0;
    reset      = 1'b1;
    bus.chen   = 16'h0001;
    bus.oready = 1'b1;

    // Reset state; give must stay low even with a pending ch0 block
    chpush(0, 16'h8004);
    for (int k = 1; k <= 4; k++) chpush(0, 16'h0100 + 16'(k));
    tick(); tick();
    chk("rst_give",   bus.give,   32'h0);
    chk("rst_odata",  bus.odata,  32'h0);
    chk("rst_ovalid", bus.ovalid, 32'h0);
    chk("rst_sop_eop", {bus.osop, bus.oeop}, 32'h0);
    chk("rst_err",    bus.err,    32'h0);
    chk("rst_blkcnt", bus.blkcnt, 32'h0);

    // 1: ch0 L=4 block, five consecutive words
    expect_w(16'h8004, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) expect_w(16'h0100 + 16'(k), 1'b0, k == 4);
    reset = 1'b0;
    drain(30, "t1_drain");
    chk("t1_consec", last_v_cyc - sop_cyc, 4);
    chk("t1_blkcnt", bus.blkcnt, 32'd1);

    // 2: ch2 then ch5, no interleave, ptr lands on 6
    bus.chen = 16'hFFFF;
    chpush(2, 16'h8402); chpush(2, 16'h2001); chpush(2, 16'h2002);
    chpush(5, 16'h8A02); chpush(5, 16'h5001); chpush(5, 16'h5002);
    expect_w(16'h8402, 1'b1, 1'b0); expect_w(16'h2001, 1'b0, 1'b0); expect_w(16'h2002, 1'b0, 1'b1);
    expect_w(16'h8A02, 1'b1, 1'b0); expect_w(16'h5001, 1'b0, 1'b0); expect_w(16'h5002, 1'b0, 1'b1);
    drain(40, "t2_drain");
    chk("t2_ptr", 32'(dut.ptr_q), 32'd6);
    chk("t2_blkcnt", bus.blkcnt, 32'd3);

    // 3: oready toggling during an L=10 block on ch7
    chpush(7, 16'h8E0A);
    expect_w(16'h8E0A, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      chpush(7, 16'h7000 + 16'(k));
      expect_w(16'h7000 + 16'(k), 1'b0, k == 10);
    end
    p0 = n_pop;
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      bus.oready = k[0];
      #1;
      if (!bus.oready) chk("t3_give_low", bus.give, 32'h0);
      tick();
    end
    chk("t3_drain", exp_q.size(), 0);
    chk("t3_words", n_pop - p0, 11);
    bus.oready = 1'b1;
    chk("t3_blkcnt", bus.blkcnt, 32'd4);

    // 4: ch9 stalls after 3 of 8 data words -> timeout abort
    chpush(9, 16'h9208);
    expect_w(16'h9208, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      chpush(9, 16'h9000 + 16'(k));
      expect_w(16'h9000 + 16'(k), 1'b0, 1'b0);
    end
    e0 = err_n;
    for (int k = 0; k < 400 && err_n == e0; k++) tick();
    chk("t4_err_seen", err_n - e0, 1);
    chk("t4_err_delay", err_cyc - last_v_cyc, 256);
    chk("t4_ptr", 32'(dut.ptr_q), 32'd10);
    chk("t4_drain", exp_q.size(), 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t4_err_once", err_n - e0, 1);
    chk("t4_blkcnt", bus.blkcnt, 32'd4);

    // 5: desynced word on ch1 dropped, following block intact
    chpush(1, 16'h1234); chpush(1, 16'h8201); chpush(1, 16'h1111);
    expect_w(16'h8201, 1'b1, 1'b0); expect_w(16'h1111, 1'b0, 1'b1);
    e0 = err_n;
    drain(60, "t5_drain");
    chk("t5_err", err_n - e0, 1);
    chk("t5_blkcnt", bus.blkcnt, 32'd5);

    // 6: only ch0 enabled; reset in the middle of its block
    bus.chen = 16'h0001;
    h3 = head[3];
    chpush(3, 16'h8601); chpush(3, 16'h3333);
    chpush(0, 16'h8003);
    for (int k = 1; k <= 3; k++) chpush(0, 16'h0A00 + 16'(k));
    expect_w(16'h8003, 1'b1, 1'b0); expect_w(16'h0A01, 1'b0, 1'b0);
    drain(40, "t6_drain");
    chk("t6_ch3_idle", head[3], h3);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_odata",  bus.odata,  32'h0);
    chk("t6_ovalid", bus.ovalid, 32'h0);
    chk("t6_sop_eop", {bus.osop, bus.oeop}, 32'h0);
    chk("t6_err",    bus.err,    32'h0);
    chk("t6_blkcnt", bus.blkcnt, 32'h0);
    chk("t6_give",   bus.give,   32'h0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_quiet", bus.blkcnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
